i2c_sensor_responder: RTL and testbench
=======================================

I2C_SENSOR_RESPONDER -- requirements
Module: i2c_sensor_responder

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h44, the 7-bit target address this responder answers to.
REQ-002 SHALL have parameter RD_LEN, default 2, the number of sensor bytes returned per read before filler is sent.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; one clock, and all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port scl_in, input, 1 bit: bus SCL level, asynchronous to clk.
REQ-006 SHALL have port sda_in, input, 1 bit: bus SDA level, asynchronous to clk.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain); 0 releases it. The top level builds the tri-state from this.
REQ-008 SHALL have port sensor_data, input, 16 bits: the live measurement presented to the master, MSB first.
REQ-009 SHALL have port snap_pulse, output, 1 bit: one-cycle strobe when sensor_data is captured for a read.
REQ-010 SHALL have port wr_data, output, 8 bits: the last byte written by the master.
REQ-011 SHALL have port wr_valid, output, 1 bit: one-cycle strobe when wr_data updates.
REQ-012 SHALL have port busy, output, 1 bit: 1 from address match until STOP or NACK-to-idle.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-flop synchronizers plus one history flop; all edge and condition detection SHALL use the synchronized signals.
REQ-014 SHALL detect START as synchronized SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1.
REQ-015 SHALL use FSM states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-016 SHALL go from any state to ADDR on START, including a repeated START mid-transfer, with the bit counter cleared to 0.
REQ-017 SHALL go from any state to IDLE on STOP, releasing sda_oe in the same cycle the STOP is detected.
REQ-018 In ADDR, SHALL sample SDA on each SCL rising edge, 8 bits MSB first, as 7 address bits plus the R/W bit.
REQ-019 On an address mismatch, SHALL go to WAIT_STOP, leave sda_oe=0 throughout, and never ACK.
REQ-020 On an address match, SHALL assert sda_oe after the SCL falling edge that follows bit 8, hold it through the 9th SCL high, and release it after the 9th SCL falling edge.
REQ-021 On a match with R/W=1, SHALL register sensor_data into a 16-bit shadow and pulse snap_pulse for 1 cycle, both on the 8th SCL rising edge.
REQ-022 With R/W=1, SHALL go to TX_BYTE after ADDR_ACK; with R/W=0, SHALL go to RX_BYTE.
REQ-023 In TX_BYTE, SHALL change SDA only on the cycle after an SCL falling edge: sda_oe = ~bit, MSB first.
  - byte 0 = shadow[15:8], byte 1 = shadow[7:0].
  - bytes at index >= RD_LEN = 8'hFF, i.e. SDA released.
REQ-024 In TX_ACK, SHALL release SDA and sample the master's bit on the SCL rising edge.
  - ACK (0): next byte in TX_BYTE.
  - NACK (1): WAIT_STOP.
REQ-025 In RX_BYTE, SHALL shift SDA on each SCL rising edge; after 8 bits it SHALL update wr_data and pulse wr_valid on that 8th rising edge, then ACK in RX_ACK with the same timing as REQ-020.
REQ-026 SHALL make the byte index an 8-bit counter that saturates at 255, with no wrap back to sensor bytes.
REQ-027 SHALL never change sda_oe while synchronized SCL=1, except when releasing it on STOP or START detection.
REQ-028 SHALL drive busy=1 in ADDR_ACK, RX_*, TX_* and WAIT_STOP after a match; busy SHALL be 0 in IDLE, in ADDR, and in WAIT_STOP after a mismatch.
REQ-029 If a START and an SCL edge are detected in the same cycle, START SHALL take priority.

Reset
REQ-030 While rst=1 at a clk edge, SHALL set: state=IDLE, sda_oe=0, snap_pulse=0, wr_valid=0, busy=0, wr_data=8'h00, shadow=16'h0000, counters=0, synchronizer flops=1.
REQ-031 Reset asserted mid-transfer SHALL release SDA on the next clk edge; after reset, SHALL ignore the bus until the next START.

Verification
REQ-032 Read 0x44 with sensor_data=16'hA53C, master ACKs byte 0 and NACKs byte 1, then STOP -> address ACKed; bytes read 0xA5, 0x3C; snap_pulse exactly once; busy returns to 0 at STOP.
REQ-033 Write to 0x44 with data 0x5A -> address ACK and data ACK; wr_data=0x5A; wr_valid high exactly 1 cycle.
REQ-034 Read to 0x23 -> sda_oe stays 0 for the whole transaction; busy stays 0; no snap_pulse.
REQ-035 Read of 3 bytes with all ACKed, sensor_data=16'h1234 -> bytes 0x12, 0x34, 0xFF.
REQ-036 Repeated START after the first read byte, then a fresh read, with sensor_data changed to 16'h0F0F -> new snapshot; bytes 0x0F, 0x0F.
REQ-037 rst pulsed during byte 0 of a read -> sda_oe=0 on the next clk edge; a following full read succeeds.

Source files
------------

// File: rtl/i2c_sensor_responder.sv
// I2C target that returns a snapshot of a 16-bit sensor value on reads and
// latches single bytes on writes. Bus lines are oversampled on clk.
module i2c_sensor_responder #(
  parameter logic [6:0] I2C_ADDR = 7'h44,
  parameter int         RD_LEN   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] sensor_data,
  output logic        snap_pulse,
  output logic [7:0]  wr_data,
  output logic        wr_valid,
  output logic        busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] RX_BYTE   = 3'd3;
  localparam logic [2:0] RX_ACK    = 3'd4;
  localparam logic [2:0] TX_BYTE   = 3'd5;
  localparam logic [2:0] TX_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  // Byte index saturates so a long read never wraps back onto sensor bytes.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] tx_byte_sel(input logic [7:0] idx, input logic [15:0] shd);
    if (idx == 8'd0 && RD_LEN > 0)
      return shd[15:8];
    else if (idx == 8'd1 && RD_LEN > 1)
      return shd[7:0];
    else
      return 8'hFF;
  endfunction

  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic [2:0]  state;
  logic [2:0]  bitcnt;
  logic [6:0]  sreg;
  logic [15:0] shadow;
  logic [7:0]  txsr;
  logic [7:0]  byteidx;
  logic        rw;
  logic        matched;
  logic        ack_on;
  logic        acked;

  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  next_byte;

  // Stage p1 is the synchronized level, p2 its one-cycle history.
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign next_byte = tx_byte_sel(byteidx, shadow);

  assign busy = matched && (state != IDLE) && (state != ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0     <= 1'b1;
      scl_p1     <= 1'b1;
      scl_p2     <= 1'b1;
      sda_p0     <= 1'b1;
      sda_p1     <= 1'b1;
      sda_p2     <= 1'b1;
      state      <= IDLE;
      bitcnt     <= 3'd0;
      sreg       <= 7'd0;
      shadow     <= 16'h0000;
      txsr       <= 8'h00;
      byteidx    <= 8'd0;
      rw         <= 1'b0;
      matched    <= 1'b0;
      ack_on     <= 1'b0;
      acked      <= 1'b0;
      sda_oe     <= 1'b0;
      snap_pulse <= 1'b0;
      wr_valid   <= 1'b0;
      wr_data    <= 8'h00;
    end else begin
      scl_p0     <= scl_in;
      scl_p1     <= scl_p0;
      scl_p2     <= scl_p1;
      sda_p0     <= sda_in;
      sda_p1     <= sda_p0;
      sda_p2     <= sda_p1;
      snap_pulse <= 1'b0;
      wr_valid   <= 1'b0;

      if (start_det) begin
        state   <= ADDR;
        bitcnt  <= 3'd0;
        byteidx <= 8'd0;
        matched <= 1'b0;
        ack_on  <= 1'b0;
        acked   <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        matched <= 1'b0;
        ack_on  <= 1'b0;
        acked   <= 1'b0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              sreg <= {sreg[5:0], sda_p1};
              if (bitcnt == 3'd7) begin
                bitcnt <= 3'd0;
                if (sreg == I2C_ADDR) begin
                  matched <= 1'b1;
                  rw      <= sda_p1;
                  ack_on  <= 1'b0;
                  state   <= ADDR_ACK;
                  if (sda_p1) begin
                    shadow     <= sensor_data;
                    snap_pulse <= 1'b1;
                  end
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bitcnt <= bitcnt + 3'd1;
              end
            end
          end

          ADDR_ACK: begin
            // First falling edge pulls ACK; the next one ends the ACK slot.
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                bitcnt <= 3'd0;
                if (rw) begin
                  txsr   <= next_byte;
                  sda_oe <= ~next_byte[7];
                  state  <= TX_BYTE;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= RX_BYTE;
                end
              end
            end
          end

          RX_BYTE: begin
            if (scl_rise) begin
              sreg <= {sreg[5:0], sda_p1};
              if (bitcnt == 3'd7) begin
                bitcnt   <= 3'd0;
                wr_data  <= {sreg, sda_p1};
                wr_valid <= 1'b1;
                ack_on   <= 1'b0;
                state    <= RX_ACK;
              end else begin
                bitcnt <= bitcnt + 3'd1;
              end
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
                bitcnt <= 3'd0;
                state  <= RX_BYTE;
              end
            end
          end

          TX_BYTE: begin
            // MSB is already on the bus at entry; each fall presents the next bit.
            if (scl_fall) begin
              if (bitcnt == 3'd7) begin
                sda_oe <= 1'b0;
                acked  <= 1'b0;
                state  <= TX_ACK;
              end else begin
                bitcnt <= bitcnt + 3'd1;
                txsr   <= {txsr[6:0], 1'b1};
                sda_oe <= ~txsr[6];
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_p1) begin
                acked   <= 1'b1;
                byteidx <= sat_inc8(byteidx);
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall && acked) begin
              acked  <= 1'b0;
              bitcnt <= 3'd0;
              txsr   <= next_byte;
              sda_oe <= ~next_byte[7];
              state  <= TX_BYTE;
            end
          end

          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Directed bench for i2c_sensor_responder: a bit-banged I2C master drives the
// bus while monitors count strobes and bus-drive activity.
module tb_i2c_sensor_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [15:0] sensor = 16'h0000;
  logic        snap_pulse;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        busy;

  int checks = 0;
  int failures = 0;

  assign sda_in = sda_m & ~sda_oe;

  i2c_sensor_responder #(.I2C_ADDR(7'h44), .RD_LEN(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
    .sensor_data(sensor), .snap_pulse(snap_pulse), .wr_data(wr_data),
    .wr_valid(wr_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int  snap_tot = 0, snap_long = 0, wrv_tot = 0, wrv_long = 0;
  int  busy_tot = 0, oe_tot = 0, viol_tot = 0, scl_hi = 0;
  logic snap_prev = 1'b0, wrv_prev = 1'b0, oe_prev = 1'b0;

  always @(negedge clk) begin
    if (snap_pulse) snap_tot++;
    if (snap_pulse && snap_prev) snap_long++;
    if (wr_valid) wrv_tot++;
    if (wr_valid && wrv_prev) wrv_long++;
    if (busy) busy_tot++;
    if (sda_oe) oe_tot++;
    if (scl_m) scl_hi++; else scl_hi = 0;
    if (!rst && scl_hi >= 5 && sda_oe != oe_prev) viol_tot++;
    snap_prev = snap_pulse;
    wrv_prev  = wr_valid;
    oe_prev   = sda_oe;
  end

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    int          nbytes;
    logic        nack_last;
    logic [15:0] sensor;
    logic [7:0]  wdata;
    logic        exp_ackbit;
    logic [7:0]  exp_b [3];
    int          exp_snap;
    int          exp_wrv;
    logic        exp_busy;
    logic [7:0]  exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] a, input logic r, input int n, input logic nl,
                              input logic [15:0] s, input logic [7:0] w, input logic ab,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int sn, input int wv, input logic bz, input logic [7:0] ew);
    vec_t v;
    v.addr = a; v.rw = r; v.nbytes = n; v.nack_last = nl; v.sensor = s; v.wdata = w;
    v.exp_ackbit = ab; v.exp_b[0] = b0; v.exp_b[1] = b1; v.exp_b[2] = b2;
    v.exp_snap = sn; v.exp_wrv = wv; v.exp_busy = bz; v.exp_wr = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic qwait();
    repeat (8) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic rstart_c();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    b = sda_in; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic wbyte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
  endtask

  task automatic rbyte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int s0, w0, b0, o0;
    logic a;
    logic [7:0] d;
    s0 = snap_tot; w0 = wrv_tot; b0 = busy_tot; o0 = oe_tot;
    sensor = v.sensor;
    start_c();
    wbyte({v.addr, v.rw});
    rbit(a);
    check("addr_ack", a, v.exp_ackbit);
    if (v.rw) begin
      for (int i = 0; i < v.nbytes; i++) begin
        rbyte(d);
        check($sformatf("rd_byte%0d", i), d, v.exp_b[i]);
        wbit((i == v.nbytes - 1) && v.nack_last);
      end
    end else begin
      wbyte(v.wdata);
      rbit(a);
      check("data_ack", a, v.exp_ackbit);
    end
    stop_c();
    check("busy_after_stop", busy, 0);
    check("snap_count", snap_tot - s0, v.exp_snap);
    check("wr_valid_count", wrv_tot - w0, v.exp_wrv);
    check("busy_seen", (busy_tot - b0) != 0, v.exp_busy);
    check("sda_driven", (oe_tot - o0) != 0, v.exp_busy);
    check("wr_data", wr_data, v.exp_wr);
  endtask

  vec_t vecs [6];

  initial begin
    logic [7:0] d;
    logic a;
    int s0, o0;

    vecs[0] = mk(7'h44, 1'b1, 2, 1'b1, 16'hA53C, 8'h00, 1'b0, 8'hA5, 8'h3C, 8'hFF, 1, 0, 1'b1, 8'h00);
    vecs[1] = mk(7'h44, 1'b0, 0, 1'b0, 16'h0000, 8'h5A, 1'b0, 8'h00, 8'h00, 8'h00, 0, 1, 1'b1, 8'h5A);
    vecs[2] = mk(7'h23, 1'b1, 2, 1'b1, 16'hA53C, 8'h00, 1'b1, 8'hFF, 8'hFF, 8'hFF, 0, 0, 1'b0, 8'h5A);
    vecs[3] = mk(7'h44, 1'b1, 3, 1'b0, 16'h1234, 8'h00, 1'b0, 8'h12, 8'h34, 8'hFF, 1, 0, 1'b1, 8'h5A);
    vecs[4] = mk(7'h45, 1'b0, 0, 1'b0, 16'h0000, 8'h3C, 1'b1, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 8'h5A);
    vecs[5] = mk(7'h44, 1'b1, 2, 1'b1, 16'h8001, 8'h00, 1'b0, 8'h80, 8'h01, 8'hFF, 1, 0, 1'b1, 8'h5A);

    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_snap", snap_pulse, 0);
    check("rst_wr_data", wr_data, 8'h00);
    rst = 1'b0;
    qwait();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Repeated START after a NACKed first byte, then a fresh snapshot.
    sensor = 16'hA53C;
    s0 = snap_tot;
    start_c();
    wbyte({7'h44, 1'b1});
    rbit(a);
    check("rs_addr_ack1", a, 0);
    rbyte(d);
    check("rs_byte0", d, 8'hA5);
    wbit(1'b1);
    sensor = 16'h0F0F;
    rstart_c();
    wbyte({7'h44, 1'b1});
    rbit(a);
    check("rs_addr_ack2", a, 0);
    rbyte(d);
    check("rs_new_byte0", d, 8'h0F);
    wbit(1'b0);
    rbyte(d);
    check("rs_new_byte1", d, 8'h0F);
    wbit(1'b1);
    stop_c();
    check("rs_snap_count", snap_tot - s0, 2);
    check("rs_busy_after_stop", busy, 0);

    // Reset while the responder is pulling SDA low inside byte 0.
    sensor = 16'hA53C;
    start_c();
    wbyte({7'h44, 1'b1});
    rbit(a);
    check("mr_addr_ack", a, 0);
    rbit(a);
    check("mr_bit7", a, 1);
    check("mr_driving_bit6", sda_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_release_on_reset", sda_oe, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mr_wr_data_cleared", wr_data, 8'h00);
    o0 = oe_tot;
    for (int i = 0; i < 4; i++) rbit(a);
    check("mr_ignores_bus", oe_tot - o0, 0);
    check("mr_busy_idle", busy, 0);
    stop_c();
    run_vec(mk(7'h44, 1'b1, 2, 1'b1, 16'hA53C, 8'h00, 1'b0, 8'hA5, 8'h3C, 8'hFF, 1, 0, 1'b1, 8'h00));

    check("snap_one_cycle", snap_long, 0);
    check("wr_valid_one_cycle", wrv_long, 0);
    check("sda_change_scl_high", viol_tot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
